// File: rtl/adc_scan_sequencer_if.sv
// Serial bus between the scan sequencer (master) and the external ADC (slave).
interface adc_scan_sequencer_if;
    logic ADC_CS_N;
    logic ADC_SCLK;
    logic ADC_DIN;
    logic ADC_DOUT;

    modport master (
        output ADC_CS_N,
        output ADC_SCLK,
        output ADC_DIN,
        input  ADC_DOUT
    );

    modport slave (
        input  ADC_CS_N,
        input  ADC_SCLK,
        input  ADC_DIN,
        output ADC_DOUT
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Autonomous scanner for a pipelined 8-channel 12-bit serial ADC.
// Define ADC_SCAN_CHK_EN to verify the returned channel id in every frame.
module adc_scan_sequencer #(
    parameter int NUM_CH  = 8,
    parameter int CLK_DIV = 4,
    parameter int QUIET   = 6
) (
    input  logic                 SYS_CLK,
    input  logic                 RESET_N,
    input  logic                 ENABLE,
    input  logic [NUM_CH-1:0]    CH_MASK,
    adc_scan_sequencer_if.master adc,
    output logic [NUM_CH*16-1:0] RESULT_REG,
    output logic [NUM_CH-1:0]    RESULT_VALID,
    output logic                 SCAN_DONE,
    output logic [15:0]          SCAN_COUNT,
    output logic                 ADC_ERR
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SHIFT, S_STORE, S_QUIET
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] Q_LAST   = 16'(QUIET - 1);

    state_t      state, state_n;
    logic        cs_n, sclk, din;
    logic [15:0] sh;
    logic [14:0] rx;
    logic [15:0] div_cnt, q_cnt;
    logic [3:0]  bit_cnt;
    logic [2:0]  cur_ch, prev_ch;
    logic [2:0]  first_ch, next_ch, hi_ch;
    logic        prime, go, tick, last_rise, id_ok, wr;

    assign go        = ENABLE && (|CH_MASK);
    assign tick      = (div_cnt == DIV_LAST);
    assign last_rise = (state == S_SHIFT) && tick && !sclk && (bit_cnt == 4'd15);
    assign wr        = prime && id_ok;

    assign adc.ADC_CS_N = cs_n;
    assign adc.ADC_SCLK = sclk;
    assign adc.ADC_DIN  = din;

`ifdef ADC_SCAN_CHK_EN
    logic err;
    assign id_ok   = (rx[14:12] == prev_ch);
    assign ADC_ERR = err;
`else
    logic unused_id;
    assign unused_id = ^rx[14:12];
    assign id_ok     = 1'b1;
    assign ADC_ERR   = 1'b0;
`endif

    // next_ch: lowest set bit above cur_ch, else wrap to the lowest set bit
    always_comb begin
        first_ch = '0;
        hi_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (CH_MASK[i]) first_ch = 3'(i);
        for (int i = 0; i < NUM_CH; i++)
            if (CH_MASK[i]) hi_ch = 3'(i);
        next_ch = first_ch;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (CH_MASK[i] && (3'(i) > cur_ch)) next_ch = 3'(i);
    end

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (go) state_n = S_START;
            S_START: state_n = S_SHIFT;
            S_SHIFT: if (last_rise) state_n = S_STORE;
            S_STORE: begin
                if (QUIET > 1)  state_n = S_QUIET;
                else if (go)    state_n = S_START;
                else            state_n = S_IDLE;
            end
            S_QUIET: begin
                if (q_cnt == Q_LAST) state_n = go ? S_START : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cs_n         <= 1'b1;
            sclk         <= 1'b1;
            din          <= 1'b0;
            sh           <= '0;
            rx           <= '0;
            div_cnt      <= '0;
            q_cnt        <= '0;
            bit_cnt      <= '0;
            cur_ch       <= '0;
            prev_ch      <= '0;
            prime        <= 1'b0;
            RESULT_REG   <= '0;
            RESULT_VALID <= '0;
            SCAN_DONE    <= 1'b0;
            SCAN_COUNT   <= '0;
`ifdef ADC_SCAN_CHK_EN
            err          <= 1'b0;
`endif
        end else begin
            SCAN_DONE <= 1'b0;
            // chip select falls on the edge that enters START
            if (state_n == S_START && state != S_START) cs_n <= 1'b0;
            case (state)
                S_IDLE: begin
                    prime  <= 1'b0;
                    cur_ch <= first_ch;
                end
                S_START: begin
                    sh      <= {1'b1, 2'b00, cur_ch, 10'd0};
                    div_cnt <= 16'd1;
                    bit_cnt <= '0;
                end
                S_SHIFT: begin
                    if (tick) begin
                        div_cnt <= '0;
                        if (sclk) begin
                            sclk <= 1'b0;
                            din  <= sh[15];
                            sh   <= {sh[14:0], 1'b0};
                        end else begin
                            sclk    <= 1'b1;
                            rx      <= {rx[13:0], adc.ADC_DOUT};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd15) cs_n <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                S_STORE: begin
                    prev_ch <= cur_ch;
                    cur_ch  <= next_ch;
                    prime   <= 1'b1;
                    q_cnt   <= 16'd1;
                    if (wr) begin
                        RESULT_REG[{prev_ch, 4'b0} +: 16] <= {4'h0, rx[11:0]};
                        RESULT_VALID[prev_ch] <= 1'b1;
                        if (prev_ch == hi_ch) begin
                            SCAN_DONE  <= 1'b1;
                            SCAN_COUNT <= SCAN_COUNT + 16'd1;
                        end
                    end
`ifdef ADC_SCAN_CHK_EN
                    if (prime && !id_ok) begin
                        err   <= 1'b1;
                        prime <= 1'b0;
                    end
`endif
                end
                S_QUIET: q_cnt <= q_cnt + 16'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural pipelined ADC.
// Expected values are hand-computed from the model's sample = base + channel.
module tb_adc_scan_sequencer;
    localparam int NUM_CH  = 8;
    localparam int CLK_DIV = 4;
    localparam int QUIET   = 6;
    localparam int FRAME   = 32 * CLK_DIV;
    localparam int BUDGET  = 20 * (FRAME + QUIET + 2);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [7:0]   mask = 8'h00;
    logic [127:0] result;
    logic [7:0]   valid;
    logic         done;
    logic [15:0]  count;
    logic         err;
    int           checks = 0;
    int           errors = 0;

    adc_scan_sequencer_if bus();

    adc_scan_sequencer #(
        .NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .QUIET(QUIET)
    ) dut (
        .SYS_CLK(clk), .RESET_N(rst_n), .ENABLE(enable), .CH_MASK(mask),
        .adc(bus), .RESULT_REG(result), .RESULT_VALID(valid),
        .SCAN_DONE(done), .SCAN_COUNT(count), .ADC_ERR(err)
    );

    always #5 clk = ~clk;

    // ADC model: frame N returns {0, id, base+ch} for the channel of frame N-1
    logic [11:0] base = 12'h000;
    int          bad_frame = -1;
    int          frame_no = 0;
    int          fall_cnt = 0;
    int          rise_cnt = 0;
    int          sclk_edges = 0;
    logic [15:0] resp = 16'h0;
    logic [15:0] din_sh = 16'h0;
    logic [15:0] din_word = 16'h0;
    logic [2:0]  prev_addr = 3'd7;
    logic [2:0]  id;
    int          addr_log[$];

    always @(negedge bus.ADC_CS_N) begin
        frame_no++;
        fall_cnt = 0;
        rise_cnt = 0;
        id = (frame_no == bad_frame) ? 3'd3 : prev_addr;
        resp = {1'b0, id, base + {9'd0, prev_addr}};
    end

    always @(negedge bus.ADC_SCLK) begin
        if (bus.ADC_CS_N === 1'b0 && fall_cnt < 16) begin
            bus.ADC_DOUT = resp[15 - fall_cnt];
            fall_cnt++;
        end
    end

    always @(posedge bus.ADC_SCLK) begin
        din_sh = {din_sh[14:0], bus.ADC_DIN};
        rise_cnt++;
        if (rise_cnt == 16) begin
            din_word  = din_sh;
            prev_addr = din_sh[12:10];
            addr_log.push_back(int'(din_sh[12:10]));
        end
    end

    always @(bus.ADC_SCLK) sclk_edges++;

    typedef struct {
        logic [7:0]  mask;
        logic [11:0] base;
        logic [2:0]  ch;
        logic [15:0] word;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cs(input logic lvl, input int budget,
                           input string name, output int n);
        n = 0;
        while (bus.ADC_CS_N !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.ADC_CS_N !== lvl) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles waiting CS_N=%0b",
                     name, n, lvl);
        end
    endtask

    task automatic wait_frame_end(input string name);
        int n;
        wait_cs(1'b0, 400, name, n);
        wait_cs(1'b1, 400, name, n);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [15:0] word_of(input logic [2:0] ch);
        return result[{ch, 4'b0} +: 16];
    endfunction

    initial begin
        int           n;
        int           n2;
        int           edges0;
        int           low_cycles;
        int           done_cycles;
        int           log0;
        int           exp_order[5];
        logic [127:0] exp_reg;

        vecs[0] = '{8'h01, 12'hABC, 3'd0, 16'h0ABC};
        vecs[1] = '{8'h01, 12'hFFF, 3'd0, 16'h0FFF};
        vecs[2] = '{8'h80, 12'h100, 3'd7, 16'h0107};
        vecs[3] = '{8'h08, 12'h0F0, 3'd3, 16'h00F3};
        vecs[4] = '{8'hA5, 12'h100, 3'd2, 16'h0102};
        vecs[5] = '{8'hA5, 12'h100, 3'd5, 16'h0105};
        vecs[6] = '{8'hFF, 12'hFF0, 3'd7, 16'h0FF7};
        vecs[7] = '{8'h02, 12'h000, 3'd1, 16'h0001};
        exp_order = '{0, 2, 5, 7, 0};

        // idle after reset
        do_reset();
        edges0 = sclk_edges;
        repeat (100) @(negedge clk);
        chk("idle_cs_n", bus.ADC_CS_N, 1'b1);
        chk("idle_sclk", bus.ADC_SCLK, 1'b1);
        chk("idle_din", bus.ADC_DIN, 1'b0);
        chk("idle_result", result, '0);
        chk("idle_valid", valid, 8'h00);
        chk("idle_done", done, 1'b0);
        chk("idle_count", count, 16'h0);
        chk("idle_err", err, 1'b0);
        chk("idle_sclk_edges", sclk_edges - edges0, 0);

        // single channel: frame timing, control word, dummy first frame
        base = 12'hABC;
        mask = 8'h01;
        enable = 1'b1;
        wait_cs(1'b0, 50, "f1_start", n);
        wait_cs(1'b1, 400, "f1_end", n);
        chk("frame_len", n, FRAME);
        chk("din_word", din_word, 16'h8000);
        wait_cs(1'b0, 50, "f2_start", n2);
        chk("quiet_len", n2, QUIET);
        chk("dummy_valid", valid, 8'h00);
        chk("dummy_word0", word_of(3'd0), 16'h0000);
        wait_cs(1'b1, 400, "f2_end", n);
        repeat (2) @(negedge clk);
        chk("f2_word0", word_of(3'd0), 16'h0ABC);
        chk("f2_valid0", valid[0], 1'b1);
        chk("f2_count", count, 16'd1);

        // table of single-result vectors
        for (int i = 0; i < 8; i++) begin
            do_reset();
            base = vecs[i].base;
            mask = vecs[i].mask;
            enable = 1'b1;
            n = 0;
            while (!valid[vecs[i].ch] && n < BUDGET) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("tbl%0d_word", i), word_of(vecs[i].ch), vecs[i].word);
            chk($sformatf("tbl%0d_valid", i), valid[vecs[i].ch], 1'b1);
            chk($sformatf("tbl%0d_unmasked", i), valid & ~vecs[i].mask, 8'h00);
            chk($sformatf("tbl%0d_err", i), err, 1'b0);
        end

        // multi-channel scan order, scan done pulses and count
        do_reset();
        base = 12'h100;
        mask = 8'hA5;
        log0 = addr_log.size();
        done_cycles = 0;
        enable = 1'b1;
        n = 0;
        while (count != 16'd3 && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (done) done_cycles++;
        end
        chk("scan_count", count, 16'd3);
        chk("scan_done_cycles", done_cycles, 3);
        for (int k = 0; k < 5; k++)
            chk($sformatf("order%0d", k),
                (addr_log.size() > log0 + k) ? addr_log[log0 + k] : -1,
                exp_order[k]);
        exp_reg = '0;
        exp_reg[0 +: 16]   = 16'h0100;
        exp_reg[32 +: 16]  = 16'h0102;
        exp_reg[80 +: 16]  = 16'h0105;
        exp_reg[112 +: 16] = 16'h0107;
        chk("scan_result", result, exp_reg);
        chk("scan_valid", valid, 8'hA5);

        // disable during channel 5's shift
        n = 0;
        while (!(bus.ADC_CS_N === 1'b0 && rise_cnt == 8 && din_sh[4:2] == 3'd5)
               && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("ch5_found", din_sh[4:2], 3'd5);
        enable = 1'b0;
        wait_cs(1'b1, 400, "ch5_end", n);
        chk("ch5_bits", rise_cnt, 16);
        edges0 = sclk_edges;
        low_cycles = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.ADC_CS_N !== 1'b1) low_cycles++;
        end
        chk("dis_cs_high", low_cycles, 0);
        chk("dis_no_sclk", sclk_edges - edges0, 0);
        chk("dis_hold", result, exp_reg);

        // re-enable: first frame is a dummy
        base = 12'h200;
        enable = 1'b1;
        wait_frame_end("reen_f1");
        chk("reen_dummy", result, exp_reg);
        chk("reen_first_ch", din_word, 16'h8000);
        wait_frame_end("reen_f2");
        chk("reen_word0", word_of(3'd0), 16'h0200);

        // reset in the middle of a frame
        n = 0;
        while (!(bus.ADC_CS_N === 1'b0 && bus.ADC_SCLK === 1'b0 && fall_cnt == 8)
               && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("mid_sclk_low", bus.ADC_SCLK, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_cs_n", bus.ADC_CS_N, 1'b1);
        chk("rst_sclk", bus.ADC_SCLK, 1'b1);
        chk("rst_result", result, '0);
        chk("rst_count", count, 16'h0);
        chk("rst_valid", valid, 8'h00);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_no_partial", result, '0);

        // returned channel id corrupted once for channel 2
        do_reset();
        base = 12'h300;
        mask = 8'h04;
        bad_frame = frame_no + 2;
        enable = 1'b1;
        wait_frame_end("chk_f1");
        wait_frame_end("chk_f2");
`ifdef ADC_SCAN_CHK_EN
        chk("chk_err", err, 1'b1);
        chk("chk_word2_kept", word_of(3'd2), 16'h0000);
        chk("chk_valid2_kept", valid[2], 1'b0);
        wait_frame_end("chk_f3");
        chk("chk_dummy_word2", word_of(3'd2), 16'h0000);
        wait_frame_end("chk_f4");
        chk("chk_word2", word_of(3'd2), 16'h0302);
        chk("chk_err_sticky", err, 1'b1);
`else
        chk("nochk_err", err, 1'b0);
        chk("nochk_word2", word_of(3'd2), 16'h0302);
        chk("nochk_valid2", valid[2], 1'b1);
        wait_frame_end("nochk_f3");
        chk("nochk_word2_again", word_of(3'd2), 16'h0302);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Upstream feeder for the SPI slave register file: autonomously scans an external 8-channel, 12-bit serial ADC and publishes results as a flat bank of 16-bit words, wired into the low words of the slave's readable register space.
- Acts as SPI master to the ADC. The ADC is pipelined: the conversion returned in frame N belongs to the channel addressed in frame N-1.

Parameters:
- NUM_CH, 8, number of ADC channels scanned (1..8).
- CLK_DIV, 4, SYS_CLK cycles per ADC_SCLK half-period (>=2).
- QUIET, 6, SYS_CLK cycles ADC_CS_N held high between frames (>=1).

Ports:
- SYS_CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- ENABLE  in  1  scanning enabled
- CH_MASK  in  NUM_CH  per-channel scan enable; bit i=1 scans channel i
- ADC_CS_N  out  1  ADC chip select, active low
- ADC_SCLK  out  1  ADC serial clock, idles high
- ADC_DIN  out  1  control word to ADC, MSB first
- ADC_DOUT  in  1  conversion data from ADC, MSB first
- RESULT_REG  out  NUM_CH*16  word i = RESULT_REG[16i+15:16i] = {4'h0, sample[11:0]}
- RESULT_VALID  out  NUM_CH  bit i set once channel i holds a real sample
- SCAN_DONE  out  1  one-cycle pulse when a full masked scan completes
- SCAN_COUNT  out  16  completed scans, wraps 16'hFFFF->0
- ADC_ERR  out  1  sticky returned-channel mismatch (feature only, else 0)

Behaviour:
- Reset (async, RESET_N=0): ADC_CS_N=1, ADC_SCLK=1, ADC_DIN=0, RESULT_REG=0, RESULT_VALID=0, SCAN_DONE=0, SCAN_COUNT=0, ADC_ERR=0, FSM=IDLE, prime flag cleared. Reset mid-frame aborts the frame immediately; no partial result is written.
- Control word: bit15=1 (write), bits12:10=channel address, all other bits 0.
- Frame: CS_N falls; 16 SCLK periods of 2*CLK_DIV SYS_CLK each.
  - DIN updates on SCLK falling edge; first bit valid CLK_DIV cycles after CS_N falls.
  - DOUT sampled on SCLK rising edge.
  - After the 16th rising edge, SCLK returns high and CS_N rises. CS_N then stays high QUIET cycles.
- Returned word: bits14:12 = channel id, bits11:0 = sample.
- FSM states: IDLE, START, SHIFT, STORE, QUIET.
  - IDLE: if ENABLE=1 and CH_MASK!=0, select the lowest set mask bit and go to START. Otherwise stay, with CS_N=1.
  - START: assert CS_N, load the shift register with the control word for the selected channel, go to SHIFT.
  - SHIFT: 16 bits via 4-bit bit counter and CLK_DIV prescaler; after bit 15 go to STORE.
  - STORE (1 cycle):
    - If the prime flag is set, write the sample into the word of the previously addressed channel (held in a pipeline register) and set its RESULT_VALID bit.
    - Set the prime flag.
    - Record the current channel as "previous".
    - Advance to the next set mask bit, wrapping to the lowest.
    - Go to QUIET.
  - QUIET: count QUIET cycles. Then go to START if ENABLE=1 and CH_MASK!=0, else to IDLE.
- First frame after IDLE is a dummy: the prime flag is clear, so nothing is written.
- Entering IDLE clears the prime flag. RESULT_REG and RESULT_VALID hold their values.
- Scan completion: when STORE writes the highest set mask bit's channel, SCAN_DONE pulses in the following cycle and SCAN_COUNT increments.
- ENABLE deasserted mid-frame: the current frame completes (including STORE), then the FSM goes to IDLE. ADC_CS_N never toggles mid-frame.
- CH_MASK changes: sampled only in STORE/IDLE. If the next channel's mask bit is now clear, the next set bit is used. A single-bit mask re-scans the same channel each frame, and SCAN_DONE pulses every frame.
- Results never glitch: RESULT_REG words change only in the STORE cycle, as a full 16-bit write.

Optional Feature:
- Macro ADC_SCAN_CHK_EN.
- Defined: in STORE, returned bits14:12 are compared with the pipeline channel.
  - On mismatch: the sample is discarded, RESULT_VALID is unchanged, ADC_ERR is set sticky (cleared only by reset), and the prime flag is cleared so the next frame is treated as a dummy.
- Undefined: no comparison; the sample is always written to the pipeline channel, and ADC_ERR is tied 0.

Test Plan:
- Reset, ENABLE=0 for 100 cycles: ADC_CS_N=1, ADC_SCLK=1, all outputs 0, no SCLK edges.
- CLK_DIV=4, CH_MASK=8'h01, ENABLE=1, ADC model returns 12'hABC for ch0.
  - Frame length 128 SYS_CLK; DIN word = 16'h8000.
  - Word 0 = 16'h0ABC and RESULT_VALID[0]=1 after the 2nd frame's STORE; nothing written after the 1st frame.
- CH_MASK=8'hA5, model returns 12'h100+ch: channel order 0,2,5,7,0.
  - Words become 16'h0100, 16'h0102, 16'h0105, 16'h0107.
  - SCAN_DONE pulses once per scan; SCAN_COUNT reaches 3 after 3 scans.
- Deassert ENABLE mid-SHIFT of ch5: frame finishes 16 bits, then CS_N rises and stays high; RESULT_REG holds. Re-enable: the first frame is a dummy.
- Pulse RESET_N low during bit 7: ADC_CS_N=1 and SCLK=1 immediately; RESULT_REG=0; SCAN_COUNT=0.
- With ADC_SCAN_CHK_EN: model returns id 3 when ch2 is expected. ADC_ERR=1, word 2 unchanged, next frame is a dummy. Without the macro, word 2 is updated and ADC_ERR=0.
